// File: rtl/soc_bus_pkg.sv
// ----------------------------------------------------------------------------
// soc_bus_pkg
// Shared definitions for the system-bus front end.
//   - FSM state encodings for the transfer sequencer (IDLE/ACCESS/RESP)
//   - transfer size codes carried on mem_size
//   - master identifiers used for last_owner / owner bookkeeping
// ----------------------------------------------------------------------------
package soc_bus_pkg;

    // Transfer sequencer states
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    // Transfer sizes, passed through to the bus untouched
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Master identifiers; the value doubles as the bit index into gnt
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_lock_arbiter.sv
// ----------------------------------------------------------------------------
// rr_lock_arbiter
// Combinational winner selection for two masters: round-robin with a bounded
// lock that lets the previous owner keep the bus while its lock is held.
// Ports:
//   req[1:0]       request lines {m1,m0}
//   lock[1:0]      lock lines {m1,m0}
//   last_owner     master that completed the most recent transfer
//   lock_cnt       consecutive locked grants already given to last_owner
//   gnt[1:0]       one-hot winner {m1,m0}, 00 when nobody requests
// ----------------------------------------------------------------------------
module rr_lock_arbiter #(
    parameter int LOCK_MAX = 4,
    parameter int CNT_W    = 3
) (
    input  logic [1:0]       req,
    input  logic [1:0]       lock,
    input  logic             last_owner,
    input  logic [CNT_W-1:0] lock_cnt,
    output logic [1:0]       gnt
);

    localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

    logic keep_owner;

    // The previous owner may only hold the bus against a competing request
    // while it keeps lock asserted and has not used up its locked grants.
    assign keep_owner = lock[last_owner] && (lock_cnt < LOCK_MAX_C);

    // A lone requester always wins; on a tie the lock decides whether the
    // previous owner stays, otherwise the bus alternates to the other master.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if (keep_owner) begin
                    gnt = last_owner ? 2'b10 : 2'b01;
                end else begin
                    gnt = last_owner ? 2'b01 : 2'b10;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
// Two-master front end for the single-master system bus. Shares the bus
// between M0 (CPU) and M1 (DMA), runs each transfer as IDLE -> ACCESS -> RESP
// and returns registered read data with a one-cycle ack to the winner.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mX_req/lock/addr/wdata/write/size   request fields from master X
//   mX_ack, mX_rdata         completion strobe and read data to master X
//   bAddr, bWData, bWrite, mem_size, bValid   bus cycle outputs (ACCESS only)
//   bRData                   muxed read data from the bus
//   gnt                      one-hot current owner {m1,m0}, 00 when idle
// ----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int LOCK_MAX = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_write,
    input  logic [1:0]        m0_size,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_write,
    input  logic [1:0]        m1_size,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] bAddr,
    output logic [DATA_W-1:0] bWData,
    output logic              bWrite,
    output logic [1:0]        mem_size,
    output logic              bValid,
    input  logic [DATA_W-1:0] bRData,
    output logic [1:0]        gnt
);

    import soc_bus_pkg::*;

    localparam int               CNT_W      = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

    logic [1:0]        state;
    logic              owner;
    logic              last_owner;
    logic [CNT_W-1:0]  lock_cnt;
    logic [1:0]        gnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;

    logic [1:0]        arb_gnt;
    logic              win_id;
    logic              win_lock;

    rr_lock_arbiter #(
        .LOCK_MAX (LOCK_MAX),
        .CNT_W    (CNT_W)
    ) u_arb (
        .req        ({m1_req, m0_req}),
        .lock       ({m1_lock, m0_lock}),
        .last_owner (last_owner),
        .lock_cnt   (lock_cnt),
        .gnt        (arb_gnt)
    );

    // gnt bit 1 is M1, so the upper bit of the one-hot grant is the winner ID.
    assign win_id   = arb_gnt[1];
    assign win_lock = win_id ? m1_lock : m0_lock;

    // Transfer sequencer. IDLE latches the winner's request so the masters
    // are free to change their fields once acked; ACCESS captures bus read
    // data for the owner (writes included); RESP hands ownership history to
    // the arbiter. The lock counter is settled at grant time so it is ready
    // together with last_owner for the next arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= M0;
            last_owner <= M1;
            lock_cnt   <= '0;
            gnt_q      <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            size_q     <= SZ_BYTE;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_gnt != 2'b00) begin
                        state   <= ACCESS;
                        gnt_q   <= arb_gnt;
                        owner   <= win_id;
                        addr_q  <= win_id ? m1_addr  : m0_addr;
                        wdata_q <= win_id ? m1_wdata : m0_wdata;
                        write_q <= win_id ? m1_write : m0_write;
                        size_q  <= win_id ? m1_size  : m0_size;
                        if ((win_id == last_owner) && win_lock) begin
                            if (lock_cnt < LOCK_MAX_C) begin
                                lock_cnt <= lock_cnt + 1'b1;
                            end
                        end else begin
                            lock_cnt <= CNT_W'(1);
                        end
                    end
                end
                ACCESS: begin
                    if (owner == M1) begin
                        m1_rdata_q <= bRData;
                    end else begin
                        m0_rdata_q <= bRData;
                    end
                    state <= RESP;
                end
                RESP: begin
                    last_owner <= owner;
                    gnt_q      <= 2'b00;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus outputs are gated by the ACCESS state so they read as zero at all
    // other times, including the cycle right after a reset aborts a write.
    assign bValid   = (state == ACCESS);
    assign bAddr    = bValid ? addr_q  : '0;
    assign bWData   = bValid ? wdata_q : '0;
    assign bWrite   = bValid & write_q;
    assign mem_size = bValid ? size_q  : 2'b00;

    assign m0_ack   = (state == RESP) && (owner == M0);
    assign m1_ack   = (state == RESP) && (owner == M1);
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign gnt      = gnt_q;

endmodule
